// File: rtl/ltl_monitor_pkg.sv
// ltl_monitor_pkg: shared symbol type, streamer states and symbol packing for the monitor interface
package ltl_monitor_pkg;
  localparam int SYMBOL_W = 8;
  typedef logic [SYMBOL_W-1:0] symbol_t;
  typedef enum logic [1:0] {RESET_HOLD, ARMED, STREAM} streamer_state_e;
  function automatic symbol_t pack_symbol(input logic [SYMBOL_W-2:0] prop);
    return {1'b0, prop};
  endfunction
endpackage

// File: rtl/ltl_symbol_fifo.sv
// ltl_symbol_fifo: small power-of-two FIFO with registered pointers/level and synchronous clear
module ltl_symbol_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head_o  = mem[rd_ptr];
  assign full_o  = level_o == (AW+1)'(DEPTH);
  assign empty_o = level_o == '0;
  always_ff @(posedge clk_i)
    if (push_i) mem[wr_ptr] <= din_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i) rd_ptr <= rd_ptr + 1'b1;
      level_o <= level_o + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/ltl_symbol_streamer.sv
// ltl_symbol_streamer: buffers proposition vectors and streams symbols with monitor reset sequencing
module ltl_symbol_streamer
  import ltl_monitor_pkg::*;
#(
  parameter int NPROP        = 7,
  parameter int DEPTH        = 4,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ev_valid_i,
  input  logic [NPROP-1:0]         ev_prop_i,
  output logic                     ev_ready_o,
  input  logic                     flush_i,
  output symbol_t                  symbols_o,
  output logic                     run_o,
  output logic                     monitor_reset_o,
  output logic [CNT_W-1:0]         sym_count_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  streamer_state_e state, state_n;
  logic [HW-1:0] hold_cnt;
  logic [NPROP-1:0] head;
  logic full, empty, push;
  ltl_symbol_fifo #(.DEPTH(DEPTH), .WIDTH(NPROP)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (run_o),
    .din_i   (ev_prop_i),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );
  // ARMED leaves on registered occupancy, so STREAM always opens with a symbol ready
  always_comb begin
    ev_ready_o      = !full && state != RESET_HOLD && !flush_i;
    push            = ev_valid_i && ev_ready_o;
    run_o           = state == STREAM && !empty;
    monitor_reset_o = state != STREAM;
    symbols_o       = run_o ? pack_symbol((SYMBOL_W-1)'(head)) : '0;
    state_n         = state == RESET_HOLD ? (hold_cnt == HW'(RESET_CYCLES - 1) ? ARMED : RESET_HOLD)
                    : state == ARMED      ? (empty ? ARMED : STREAM)
                    : STREAM;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state       <= RESET_HOLD;
      hold_cnt    <= '0;
      sym_count_o <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= state_n == RESET_HOLD ? hold_cnt + 1'b1 : '0;
      if (run_o && !(&sym_count_o)) sym_count_o <= sym_count_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_ltl_symbol_streamer.sv
// tb_ltl_symbol_streamer: scoreboard bench; pushes queue expected symbols, a monitor checks each run_o cycle
module tb_ltl_symbol_streamer;
  logic       clk = 0, rst_ni = 0, ev_valid = 0, flush = 0;
  logic [6:0] ev_prop = '0;
  logic       ready, run, mreset;
  logic [7:0] symbols;
  logic [3:0] cnt;
  logic [1:0] level;
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_sym;

  ltl_symbol_streamer #(.NPROP(7), .DEPTH(2), .RESET_CYCLES(2), .CNT_W(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .ev_valid_i      (ev_valid),
    .ev_prop_i       (ev_prop),
    .ev_ready_o      (ready),
    .flush_i         (flush),
    .symbols_o       (symbols),
    .run_o           (run),
    .monitor_reset_o (mreset),
    .sym_count_o     (cnt),
    .fifo_level_o    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk)
    if (run === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stray_symbol: got %0h expected no symbol", symbols);
      end else begin
        exp_sym = exp_q.pop_front();
        if (symbols !== exp_sym) begin
          fails++;
          $display("FAIL symbol: got %0h expected %0h", symbols, exp_sym);
        end
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] p);
    ev_valid = 1;
    ev_prop  = p;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        exp_q.push_back({1'b0, p});
        step();
        ev_valid = 0;
        return;
      end
      step();
    end
    tests++;
    fails++;
    $display("FAIL push_timeout: got ready=0 expected ready=1 within 20 cycles");
    ev_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mreset", mreset, 1);
    check("rst_run", run, 0);
    check("rst_ready", ready, 0);
    check("rst_cnt", cnt, 0);
    check("rst_level", level, 0);
    check("rst_symbols", symbols, 0);
    step();
    rst_ni = 1;
    @(negedge clk);
    check("hold0_ready", ready, 0);
    check("hold0_mreset", mreset, 1);
    step();
    @(negedge clk);
    check("hold1_ready", ready, 0);
    step();
    @(negedge clk);
    check("armed_ready", ready, 1);
    check("armed_mreset", mreset, 1);
    check("armed_run", run, 0);
    repeat (5) step();
    @(negedge clk);
    check("idle_mreset", mreset, 1);
    check("idle_run", run, 0);
    step();
    // first symbol out of ARMED
    push(7'h05);
    @(negedge clk);
    check("armed_level", level, 1);
    check("armed_hold_mreset", mreset, 1);
    check("armed_hold_run", run, 0);
    step();
    @(negedge clk);
    check("first_mreset", mreset, 0);
    check("first_run", run, 1);
    step();
    @(negedge clk);
    check("after_first_run", run, 0);
    check("after_first_cnt", cnt, 1);
    check("after_first_level", level, 0);
    step();
    // back-to-back in STREAM
    push(7'h12);
    push(7'h45);
    push(7'h7F);
    repeat (3) step();
    @(negedge clk);
    check("stream_cnt", cnt, 4);
    check("stream_level", level, 0);
    step();
    // fill: flush back to ARMED, then push two so FIFO is full entering STREAM
    flush = 1;
    step();
    flush = 0;
    @(negedge clk);
    check("flush_cnt", cnt, 0);
    check("flush_mreset", mreset, 1);
    step();
    step();
    push(7'h21);
    push(7'h22);
    ev_valid = 1;
    ev_prop  = 7'h23;
    @(negedge clk);
    check("full_level", level, 2);
    check("full_ready", ready, 0);
    step();
    push(7'h23);
    repeat (3) step();
    @(negedge clk);
    check("fill_cnt", cnt, 3);
    check("fill_level", level, 0);
    step();
    // flush with entries queued
    flush = 1;
    step();
    flush = 0;
    step();
    step();
    push(7'h31);
    push(7'h32);
    flush = 1;
    @(negedge clk);
    check("flush_cycle_ready", ready, 0);
    step();
    flush = 0;
    exp_q.delete();
    @(negedge clk);
    check("flushed_level", level, 0);
    check("flushed_mreset", mreset, 1);
    check("flushed_cnt", cnt, 0);
    check("flushed_run", run, 0);
    step();
    flush = 1;
    @(negedge clk);
    check("reflush_ready", ready, 0);
    step();
    flush = 0;
    @(negedge clk);
    check("rehold0_ready", ready, 0);
    step();
    @(negedge clk);
    check("rehold1_ready", ready, 0);
    check("rehold1_mreset", mreset, 1);
    step();
    @(negedge clk);
    check("rearmed_ready", ready, 1);
    check("rearmed_run", run, 0);
    step();
    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) push(7'h40 + 7'(i));
    repeat (4) step();
    @(negedge clk);
    check("sat_cnt", cnt, 15);
    check("sat_run", run, 0);
    check("sat_level", level, 0);
    step();
    // mid-stream reset
    push(7'h11);
    push(7'h22);
    rst_ni = 0;
    @(negedge clk);
    check("prereset_run", run, 1);
    step();
    exp_q.delete();
    @(negedge clk);
    check("midrst_run", run, 0);
    check("midrst_mreset", mreset, 1);
    check("midrst_ready", ready, 0);
    check("midrst_cnt", cnt, 0);
    check("midrst_level", level, 0);
    check("midrst_symbols", symbols, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
